// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time of STAGE PWM lanes from each hsync frame
// marker, recovers the per-lane duty value and streams the values out one lane
// per valid/ready transfer in ascending lane order.
module pwm_capture #(
  parameter  int STAGE  = 8,
  parameter  int DWIDTH = 8,
  localparam int IW     = $clog2(STAGE)
) (
  input  logic              clkforcounter,
  input  logic              rst,
  input  logic              hsync,
  input  logic [STAGE-1:0]  pwm_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic [IW-1:0]     out_idx,
  output logic              busy,
  output logic              frame_done,
  output logic              sat,
  output logic              overrun
);

  // The timeout counter needs one bit more than a lane count to reach 2^DWIDTH+1.
  localparam int              TW        = DWIDTH + 1;
  localparam logic [DWIDTH-1:0] CNT_MAX = '1;
  localparam logic [TW-1:0]   TMO_LIMIT = TW'((1 << DWIDTH) + 1);
  localparam logic [IW-1:0]   LAST_LANE = IW'(STAGE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] cnt_q [STAGE];
  logic [DWIDTH-1:0] cnt_d [STAGE];
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [IW-1:0]     lane_q, lane_d;
  logic              sat_q, sat_d;
  logic              frameDone_q, frameDone_d;
  logic              overrun_q, overrun_d;
  logic              hsyncPrev_q;
  logic              rise;

  assign rise = hsync & ~hsyncPrev_q;

  // Next-state logic: frame start, per-lane accumulation with saturation, timeout, unload handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    lane_d      = lane_q;
    sat_d       = sat_q;
    frameDone_d = 1'b0;
    overrun_d   = rise && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (rise) begin
          sat_d  = 1'b0;
          lane_d = '0;
          tmo_d  = TW'(1);
          for (int i = 0; i < STAGE; i++) begin
            cnt_d[i] = DWIDTH'(pwm_in[i]);
          end
          state_d = (pwm_in == '0) ? UNLOAD : MEASURE;
        end
      end

      MEASURE: begin
        if (pwm_in == '0) begin
          state_d = UNLOAD;
        end else begin
          for (int i = 0; i < STAGE; i++) begin
            if (pwm_in[i]) begin
              if (cnt_q[i] == CNT_MAX) begin
                sat_d = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + DWIDTH'(1);
              end
            end
          end
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TMO_LIMIT) begin
            state_d = UNLOAD;
            sat_d   = 1'b1;
          end
        end
      end

      UNLOAD: begin
        if (out_ready) begin
          if (lane_q == LAST_LANE) begin
            lane_d      = '0;
            state_d     = IDLE;
            frameDone_d = 1'b1;
          end else begin
            lane_d = lane_q + IW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset discards any frame in progress.
  always_ff @(posedge clkforcounter) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < STAGE; i++) begin
        cnt_q[i] <= '0;
      end
      tmo_q       <= '0;
      lane_q      <= '0;
      sat_q       <= 1'b0;
      frameDone_q <= 1'b0;
      overrun_q   <= 1'b0;
      hsyncPrev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      lane_q      <= lane_d;
      sat_q       <= sat_d;
      frameDone_q <= frameDone_d;
      overrun_q   <= overrun_d;
      hsyncPrev_q <= hsync;
    end
  end

  assign out_valid  = (state_q == UNLOAD);
  assign out_data   = out_valid ? cnt_q[lane_q] : '0;
  assign out_idx    = lane_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frameDone_q;
  assign sat        = sat_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed frames with hand-computed lane widths, checked
// cycle by cycle through immediate assertions.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       hsync;
  logic [7:0] pwmIn;
  logic       outReady;
  logic       outValid;
  logic [7:0] outData;
  logic [2:0] outIdx;
  logic       busy;
  logic       frameDone;
  logic       sat;
  logic       overrun;

  int compCount = 0;
  int errCount  = 0;

  pwm_capture #(.STAGE(8), .DWIDTH(8)) dut (
    .clkforcounter (clk),
    .rst           (rst),
    .hsync         (hsync),
    .pwm_in        (pwmIn),
    .out_ready     (outReady),
    .out_valid     (outValid),
    .out_data      (outData),
    .out_idx       (outIdx),
    .busy          (busy),
    .frame_done    (frameDone),
    .sat           (sat),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame: lane i high for wv[8i+:8] samples starting at the hsync rise.
  // If orunAt >= 1, hsync dips the cycle before orunAt so a second rise lands mid-frame.
  task automatic applyStimulus(input logic [63:0] wv, input int orunAt);
    int j;
    logic [7:0] p;
    hsync = 1'b1;
    j = 0;
    do begin
      for (int i = 0; i < 8; i++) p[i] = (j < int'(wv[8*i +: 8]));
      if (orunAt >= 0) hsync = (j != orunAt - 1);
      pwmIn = p;
      tick();
      checkOutput("busy_meas", 32'(busy), 32'd1);
      checkOutput("valid_meas", 32'(outValid), 32'(p == 8'h00));
      if (orunAt >= 0) checkOutput($sformatf("overrun_j%0d", j), 32'(overrun), 32'(j == orunAt));
      j++;
    end while (p != 8'h00);
    pwmIn = 8'h00;
  endtask

  // Walks the unload phase, optionally stalling each lane for one cycle first.
  task automatic expectUnload(input logic [63:0] wv, input bit toggleReady, input bit expSat);
    for (int k = 0; k < 8; k++) begin
      if (toggleReady) begin
        outReady = 1'b0;
        checkOutput("valid_stall", 32'(outValid), 32'd1);
        checkOutput($sformatf("idx_stall%0d", k), 32'(outIdx), 32'(k));
        checkOutput($sformatf("data_stall%0d", k), 32'(outData), 32'(wv[8*k +: 8]));
        tick();
      end
      outReady = 1'b1;
      checkOutput("valid_unload", 32'(outValid), 32'd1);
      checkOutput($sformatf("idx%0d", k), 32'(outIdx), 32'(k));
      checkOutput($sformatf("data%0d", k), 32'(outData), 32'(wv[8*k +: 8]));
      checkOutput("done_early", 32'(frameDone), 32'd0);
      tick();
    end
    checkOutput("valid_end", 32'(outValid), 32'd0);
    checkOutput("frame_done", 32'(frameDone), 32'd1);
    checkOutput("busy_end", 32'(busy), 32'd0);
    checkOutput("sat_end", 32'(sat), 32'(expSat));
    hsync = 1'b0;
    tick();
    checkOutput("done_pulse", 32'(frameDone), 32'd0);
    checkOutput("sat_hold", 32'(sat), 32'(expSat));
  endtask

  // Directed sequence of frames.
  initial begin
    rst      = 1'b1;
    hsync    = 1'b0;
    pwmIn    = 8'h00;
    outReady = 1'b1;
    tick();
    tick();
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_data", 32'(outData), 32'd0);
    checkOutput("rst_idx", 32'(outIdx), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(frameDone), 32'd0);
    checkOutput("rst_sat", 32'(sat), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] ascending widths 0..7");
    applyStimulus(64'h0706050403020100, -1);
    expectUnload(64'h0706050403020100, 1'b0, 1'b0);

    $display("[TB] mixed widths including exact full scale");
    applyStimulus(64'h107F018000FF3CA5, -1);
    expectUnload(64'h107F018000FF3CA5, 1'b0, 1'b0);

    $display("[TB] all lanes low at frame start");
    applyStimulus(64'h0000000000000000, -1);
    expectUnload(64'h0000000000000000, 1'b0, 1'b0);

    $display("[TB] lane 2 stuck high, timeout");
    hsync = 1'b1;
    for (int j = 0; j <= 256; j++) begin
      pwmIn = (j < 32) ? 8'hFF : 8'h04;
      tick();
      if (j == 254) checkOutput("sat_before", 32'(sat), 32'd0);
      if (j == 255) begin
        checkOutput("sat_at_max", 32'(sat), 32'd1);
        checkOutput("valid_before_tmo", 32'(outValid), 32'd0);
        checkOutput("busy_before_tmo", 32'(busy), 32'd1);
      end
      if (j == 256) checkOutput("valid_at_tmo", 32'(outValid), 32'd1);
    end
    expectUnload(64'h2020202020FF2020, 1'b0, 1'b1);
    pwmIn = 8'h00;

    $display("[TB] out_ready toggling during unload");
    applyStimulus(64'h180A03110C050E02, -1);
    expectUnload(64'h180A03110C050E02, 1'b1, 1'b0);

    $display("[TB] second hsync rise mid-measure");
    applyStimulus(64'h0C0B0A0908070605, 4);
    expectUnload(64'h0C0B0A0908070605, 1'b0, 1'b0);

    $display("[TB] reset mid-measure");
    hsync = 1'b1;
    pwmIn = 8'hFF;
    for (int j = 0; j < 10; j++) tick();
    checkOutput("busy_pre_rst", 32'(busy), 32'd1);
    rst   = 1'b1;
    hsync = 1'b0;
    tick();
    checkOutput("mid_rst_valid", 32'(outValid), 32'd0);
    checkOutput("mid_rst_data", 32'(outData), 32'd0);
    checkOutput("mid_rst_idx", 32'(outIdx), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_done", 32'(frameDone), 32'd0);
    checkOutput("mid_rst_sat", 32'(sat), 32'd0);
    checkOutput("mid_rst_overrun", 32'(overrun), 32'd0);
    rst   = 1'b0;
    pwmIn = 8'h00;
    tick();
    checkOutput("idle_after_rst", 32'(busy), 32'd0);
    applyStimulus(64'h0001020304050607, -1);
    expectUnload(64'h0001020304050607, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
